// File: rtl/test_run_scheduler.sv
// Test run scheduler: walks a host-configured address range in CHUNK-sized
// runs on a test control unit. Each run waits for PLL lock (first run only),
// programs the start/end addresses, sets go and polls until go clears.
// All host and control-unit traffic is single-cycle, Avalon-MM style.
module test_run_scheduler #(
    parameter int POLL_GAP = 4,
    parameter int TIMEOUT  = 65535
) (
    input  logic        avalon_clock,
    input  logic        resetn,
    input  logic        s_write,
    input  logic        s_read,
    input  logic [2:0]  s_address,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        m_write,
    output logic        m_read,
    output logic [2:0]  m_address,
    output logic [31:0] m_writedata,
    input  logic [31:0] m_readdata,
    output logic        busy,
    output logic        irq
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] LOCK_RD  = 4'd1;
    localparam logic [3:0] LOCK_CHK = 4'd2;
    localparam logic [3:0] WR_ADDR  = 4'd3;
    localparam logic [3:0] WR_NUM   = 4'd4;
    localparam logic [3:0] WR_GO    = 4'd5;
    localparam logic [3:0] POLL_RD  = 4'd6;
    localparam logic [3:0] POLL_CHK = 4'd7;
    localparam logic [3:0] GAP      = 4'd8;
    localparam logic [3:0] NEXT     = 4'd9;
    localparam logic [3:0] FINISH   = 4'd10;

    localparam logic [12:0] ADDR_LIMIT_C = 13'd2048;
    localparam logic [11:0] END_LIMIT_C  = 12'd2048;
    localparam logic [15:0] TIMEOUT_C    = 16'(TIMEOUT);
    localparam logic [15:0] GAP_LAST_C   = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;

    logic [3:0]  state_r, state_nxt_s;
    logic [10:0] base_r;
    logic [11:0] chunk_r, lat_chunk_r;
    logic [7:0]  runs_r, lat_runs_r, runs_done_r, runs_next_s;
    logic [11:0] cur_addr_r, end_s;
    logic [12:0] sum_s;
    logic [15:0] last_cycles_r, run_cnt_r, gap_cnt_r;
    logic        done_r, timeout_err_r, abort_seen_r;
    logic        ctrl_wr_s, start_s, abort_s, in_run_s, poll_phase_s, timeout_s, kill_s;
    logic        mw_s, mr_s;
    logic [2:0]  ma_s;
    logic [31:0] md_s;
    logic        unused_s;

    // Decode host commands, run-end address and abort/timeout conditions
    always_comb begin
        ctrl_wr_s    = s_write && (s_address == 3'd0);
        in_run_s     = (state_r != IDLE) && (state_r != FINISH);
        start_s      = ctrl_wr_s && s_writedata[0] && (state_r == IDLE) &&
                       (runs_r != 8'd0) && (chunk_r != 12'd0);
        abort_s      = ctrl_wr_s && s_writedata[1] && in_run_s;
        poll_phase_s = (state_r == POLL_RD) || (state_r == POLL_CHK) || (state_r == GAP);
        timeout_s    = poll_phase_s && (run_cnt_r >= TIMEOUT_C);
        sum_s        = {1'b0, cur_addr_r} + {1'b0, lat_chunk_r};
        end_s        = (sum_s >= ADDR_LIMIT_C) ? END_LIMIT_C : sum_s[11:0];
        runs_next_s  = runs_done_r + 8'd1;
        unused_s     = ^{m_readdata[31:1], s_writedata[31:12]};
    end

    // Next-state logic; abort and timeout pre-empt the normal sequence
    always_comb begin
        state_nxt_s = state_r;
        kill_s      = 1'b0;
        if (abort_s || timeout_s) begin
            state_nxt_s = FINISH;
            kill_s      = 1'b1;
        end else begin
            case (state_r)
                IDLE:     state_nxt_s = start_s ? LOCK_RD : IDLE;
                LOCK_RD:  state_nxt_s = LOCK_CHK;
                LOCK_CHK: state_nxt_s = m_readdata[0] ? WR_ADDR : LOCK_RD;
                WR_ADDR:  state_nxt_s = WR_NUM;
                WR_NUM:   state_nxt_s = WR_GO;
                WR_GO:    state_nxt_s = GAP;
                POLL_RD:  state_nxt_s = POLL_CHK;
                POLL_CHK: state_nxt_s = m_readdata[0] ? GAP : NEXT;
                GAP:      state_nxt_s = (gap_cnt_r >= GAP_LAST_C) ? POLL_RD : GAP;
                NEXT:     state_nxt_s = ((runs_next_s == lat_runs_r) || (end_s == END_LIMIT_C)) ?
                                        FINISH : WR_ADDR;
                FINISH:   state_nxt_s = IDLE;
                default:  state_nxt_s = IDLE;
            endcase
        end
    end

    // Master strobe for the state being entered, so the pulse lines up with it
    always_comb begin
        mw_s = 1'b0;
        mr_s = 1'b0;
        ma_s = 3'd0;
        md_s = 32'd0;
        if (kill_s) begin
            mw_s = 1'b1;
        end else begin
            case (state_nxt_s)
                LOCK_RD: begin
                    mr_s = 1'b1;
                    ma_s = 3'd3;
                end
                WR_ADDR: begin
                    mw_s = 1'b1;
                    ma_s = 3'd1;
                    md_s = {20'd0, (state_r == NEXT) ? end_s : cur_addr_r};
                end
                WR_NUM: begin
                    mw_s = 1'b1;
                    ma_s = 3'd2;
                    md_s = {20'd0, end_s};
                end
                WR_GO: begin
                    mw_s = 1'b1;
                    md_s = 32'd1;
                end
                POLL_RD: begin
                    mr_s = 1'b1;
                end
                default: begin
                    mw_s = 1'b0;
                end
            endcase
        end
    end

    // State register and registered master-port / busy outputs
    always_ff @(posedge avalon_clock) begin
        if (!resetn) begin
            state_r     <= IDLE;
            m_write     <= 1'b0;
            m_read      <= 1'b0;
            m_address   <= 3'd0;
            m_writedata <= 32'd0;
            busy        <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            m_write     <= mw_s;
            m_read      <= mr_s;
            m_address   <= ma_s;
            m_writedata <= md_s;
            busy        <= (state_nxt_s != IDLE) && (state_nxt_s != FINISH);
        end
    end

    // Host configuration registers; they only reach the batch when latched at start
    always_ff @(posedge avalon_clock) begin
        if (!resetn) begin
            base_r  <= 11'd0;
            chunk_r <= 12'd0;
            runs_r  <= 8'd0;
        end else if (s_write) begin
            case (s_address)
                3'd1:    base_r  <= s_writedata[10:0];
                3'd2:    chunk_r <= s_writedata[11:0];
                3'd3:    runs_r  <= s_writedata[7:0];
                default: runs_r  <= runs_r;
            endcase
        end
    end

    // Batch status, progress counters and the interrupt level
    always_ff @(posedge avalon_clock) begin
        if (!resetn) begin
            done_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            abort_seen_r  <= 1'b0;
            irq           <= 1'b0;
            runs_done_r   <= 8'd0;
            cur_addr_r    <= 12'd0;
            lat_chunk_r   <= 12'd0;
            lat_runs_r    <= 8'd0;
            last_cycles_r <= 16'd0;
        end else if (start_s) begin
            done_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            abort_seen_r  <= 1'b0;
            irq           <= 1'b0;
            runs_done_r   <= 8'd0;
            cur_addr_r    <= {1'b0, base_r};
            lat_chunk_r   <= chunk_r;
            lat_runs_r    <= runs_r;
        end else begin
            if (ctrl_wr_s) begin
                irq <= 1'b0;
            end
            if (state_r == FINISH) begin
                done_r <= 1'b1;
                irq    <= 1'b1;
            end
            if (kill_s && timeout_s) begin
                timeout_err_r <= 1'b1;
            end
            if (kill_s && abort_s) begin
                abort_seen_r <= 1'b1;
            end
            if (state_r == NEXT) begin
                runs_done_r <= runs_next_s;
                cur_addr_r  <= end_s;
            end
            if ((state_r == POLL_CHK) && !m_readdata[0] && !kill_s) begin
                last_cycles_r <= run_cnt_r;
            end
        end
    end

    // Run cycle counter (saturating) and poll gap counter
    always_ff @(posedge avalon_clock) begin
        if (!resetn) begin
            run_cnt_r <= 16'd0;
            gap_cnt_r <= 16'd0;
        end else begin
            if (state_r == WR_GO) begin
                run_cnt_r <= 16'd0;
            end else if (poll_phase_s && (run_cnt_r != 16'hFFFF)) begin
                run_cnt_r <= run_cnt_r + 16'd1;
            end
            gap_cnt_r <= (state_r == GAP) ? gap_cnt_r + 16'd1 : 16'd0;
        end
    end

    // Registered host read mux; unmapped addresses read as zero
    always_ff @(posedge avalon_clock) begin
        if (!resetn) begin
            s_readdata <= 32'd0;
        end else if (s_read) begin
            case (s_address)
                3'd0:    s_readdata <= {28'd0, abort_seen_r, timeout_err_r, done_r, busy};
                3'd1:    s_readdata <= {21'd0, base_r};
                3'd2:    s_readdata <= {20'd0, chunk_r};
                3'd3:    s_readdata <= {24'd0, runs_r};
                3'd4:    s_readdata <= {24'd0, runs_done_r};
                3'd5:    s_readdata <= {16'd0, last_cycles_r};
                default: s_readdata <= 32'd0;
            endcase
        end else begin
            s_readdata <= 32'd0;
        end
    end

endmodule

// File: tb/tb_test_run_scheduler.sv
// Directed bench for test_run_scheduler with a small test-control-unit model.
module tb_test_run_scheduler;

    logic        avalon_clock = 1'b0;
    logic        resetn;
    logic        s_write, s_read;
    logic [2:0]  s_address;
    logic [31:0] s_writedata, s_readdata;
    logic        m_write, m_read;
    logic [2:0]  m_address;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata = 32'd0;
    logic        busy, irq;

    test_run_scheduler #(.POLL_GAP(4), .TIMEOUT(200)) dut (
        .avalon_clock(avalon_clock), .resetn(resetn),
        .s_write(s_write), .s_read(s_read), .s_address(s_address),
        .s_writedata(s_writedata), .s_readdata(s_readdata),
        .m_write(m_write), .m_read(m_read), .m_address(m_address),
        .m_writedata(m_writedata), .m_readdata(m_readdata),
        .busy(busy), .irq(irq)
    );

    always #5 avalon_clock = ~avalon_clock;

    // control unit model state
    logic        lock_val = 1'b1;
    logic        clear_en = 1'b1;
    logic        go_q = 1'b0;
    int          go_timer = 0;
    int          cyc = 0;
    int          go1_cyc = 0;
    int          go0_cyc = 0;
    int          excl_err = 0;
    int          lock_reads = 0;
    int          other_reads = 0;
    logic [34:0] wlog[$];
    logic [34:0] exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Control unit model: logs writes, clears go 40 cycles after set, answers reads
    always @(posedge avalon_clock) begin
        cyc <= cyc + 1;
        if (m_write) begin
            wlog.push_back({m_address, m_writedata});
        end
        if (!resetn) begin
            go_q       <= 1'b0;
            go_timer   <= 0;
            m_readdata <= 32'd0;
        end else begin
            if (m_write && m_read) excl_err <= excl_err + 1;
            if (m_write && (m_address == 3'd0)) begin
                if (m_writedata[0]) begin
                    go_q     <= 1'b1;
                    go_timer <= 0;
                    go1_cyc  <= cyc;
                end else begin
                    go_q    <= 1'b0;
                    go0_cyc <= cyc;
                end
            end else if (go_q && clear_en) begin
                if (go_timer == 39) go_q <= 1'b0;
                go_timer <= go_timer + 1;
            end
            if (m_read) begin
                if (m_address == 3'd3) begin
                    m_readdata <= {31'd0, lock_val};
                    lock_reads <= lock_reads + 1;
                end else begin
                    m_readdata  <= (m_address == 3'd0) ? {31'd0, go_q} : 32'd0;
                    other_reads <= other_reads + 1;
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [34:0] wr(input logic [2:0] a, input logic [31:0] d);
        return {a, d};
    endfunction

    function automatic logic [31:0] pack(input logic [34:0] e);
        return {e[34:32], e[28:0]};
    endfunction

    task automatic check_log(input string tag, input int ls);
        check_val($sformatf("%s_len", tag), 32'(wlog.size() - ls), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (ls + i < wlog.size())
                check_val($sformatf("%s_w%0d", tag, i), pack(wlog[ls + i]), pack(exp_q[i]));
        end
    endtask

    task automatic host_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge avalon_clock);
        s_write = 1'b1; s_address = a; s_writedata = d;
        @(negedge avalon_clock);
        s_write = 1'b0; s_address = 3'd0; s_writedata = 32'd0;
    endtask

    task automatic host_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge avalon_clock);
        s_read = 1'b1; s_address = a;
        @(negedge avalon_clock);
        s_read = 1'b0; s_address = 3'd0;
        d = s_readdata;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge avalon_clock);
            n++;
        end
        check_val($sformatf("%s_finished", tag), {31'd0, busy}, 32'd0);
        repeat (2) @(negedge avalon_clock);
    endtask

    task automatic setup(input logic [31:0] b, input logic [31:0] c, input logic [31:0] r);
        host_write(3'd1, b);
        host_write(3'd2, c);
        host_write(3'd3, r);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int ls, lr0, or0, n;
        resetn = 1'b0; s_write = 1'b0; s_read = 1'b0;
        s_address = 3'd0; s_writedata = 32'd0;
        repeat (3) @(negedge avalon_clock);
        resetn = 1'b1;
        @(negedge avalon_clock);

        // reset state
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_irq", {31'd0, irq}, 32'd0);
        check_val("rst_mwrite", {31'd0, m_write}, 32'd0);
        check_val("rst_mread", {31'd0, m_read}, 32'd0);
        host_read(3'd0, rd); check_val("rst_ctrl", rd, 32'd0);

        // two full runs
        lock_val = 1'b1; clear_en = 1'b1;
        setup(32'd0, 32'd256, 32'd2);
        ls = wlog.size();
        host_write(3'd0, 32'd1);
        check_val("t1_busy", {31'd0, busy}, 32'd1);
        wait_done("t1");
        exp_q = {wr(3'd1, 32'd0), wr(3'd2, 32'd256), wr(3'd0, 32'd1),
                 wr(3'd1, 32'd256), wr(3'd2, 32'd512), wr(3'd0, 32'd1)};
        check_log("t1", ls);
        host_read(3'd4, rd); check_val("t1_runs_done", rd, 32'd2);
        host_read(3'd5, rd); check_val("t1_last_cycles", rd, 32'd41);
        check_val("t1_irq", {31'd0, irq}, 32'd1);
        host_read(3'd0, rd); check_val("t1_ctrl", rd, 32'd2);
        host_write(3'd0, 32'd0);
        check_val("t1_irq_clr", {31'd0, irq}, 32'd0);
        host_read(3'd0, rd); check_val("t1_ctrl_kept", rd, 32'd2);

        // end clamped at 2048 stops the batch early
        setup(32'd1900, 32'd256, 32'd4);
        ls = wlog.size();
        host_write(3'd0, 32'd1);
        wait_done("t2");
        exp_q = {wr(3'd1, 32'd1900), wr(3'd2, 32'd2048), wr(3'd0, 32'd1)};
        check_log("t2", ls);
        host_read(3'd4, rd); check_val("t2_runs_done", rd, 32'd1);
        host_read(3'd0, rd); check_val("t2_ctrl", rd, 32'd2);

        // PLL lock held low for 100 cycles
        lock_val = 1'b0;
        setup(32'd100, 32'd50, 32'd1);
        ls = wlog.size(); lr0 = lock_reads; or0 = other_reads;
        host_write(3'd0, 32'd1);
        repeat (100) @(negedge avalon_clock);
        check_val("t3_lock_polled", {31'd0, (lock_reads > lr0)}, 32'd1);
        check_val("t3_other_reads", 32'(other_reads - or0), 32'd0);
        check_val("t3_no_writes", 32'(wlog.size() - ls), 32'd0);
        lock_val = 1'b1;
        wait_done("t3");
        exp_q = {wr(3'd1, 32'd100), wr(3'd2, 32'd150), wr(3'd0, 32'd1)};
        check_log("t3", ls);
        host_read(3'd4, rd); check_val("t3_runs_done", rd, 32'd1);

        // go never clears: timeout
        clear_en = 1'b0;
        setup(32'd0, 32'd16, 32'd1);
        ls = wlog.size();
        host_write(3'd0, 32'd1);
        wait_done("t4");
        exp_q = {wr(3'd1, 32'd0), wr(3'd2, 32'd16), wr(3'd0, 32'd1), wr(3'd0, 32'd0)};
        check_log("t4", ls);
        check_val("t4_timeout_cycles", 32'(go0_cyc - go1_cyc), 32'd202);
        host_read(3'd0, rd); check_val("t4_ctrl", rd, 32'd6);
        check_val("t4_irq", {31'd0, irq}, 32'd1);
        check_val("t4_busy", {31'd0, busy}, 32'd0);
        clear_en = 1'b1;

        // abort during the gap of run 1 of 3
        setup(32'd0, 32'd8, 32'd3);
        ls = wlog.size();
        host_write(3'd0, 32'd1);
        n = 0;
        while ((wlog.size() - ls) < 3 && n < 500) begin
            @(negedge avalon_clock);
            n++;
        end
        check_val("t5_go_seen", 32'(wlog.size() - ls), 32'd3);
        host_write(3'd0, 32'd2);
        wait_done("t5");
        exp_q = {wr(3'd1, 32'd0), wr(3'd2, 32'd8), wr(3'd0, 32'd1), wr(3'd0, 32'd0)};
        check_log("t5", ls);
        host_read(3'd4, rd); check_val("t5_runs_done", rd, 32'd0);
        host_read(3'd0, rd); check_val("t5_ctrl", rd, 32'd10);
        check_val("t5_irq", {31'd0, irq}, 32'd1);

        // abort while idle, start with RUNS=0: both ignored
        host_write(3'd0, 32'd2);
        host_read(3'd0, rd); check_val("t5_idle_abort", rd, 32'd10);
        host_write(3'd3, 32'd0);
        host_write(3'd0, 32'd1);
        check_val("t5_zero_runs_busy", {31'd0, busy}, 32'd0);
        host_read(3'd0, rd); check_val("t5_zero_runs_ctrl", rd, 32'd10);

        // reset during WR_NUM
        setup(32'd0, 32'd32, 32'd2);
        ls = wlog.size();
        host_write(3'd0, 32'd1);
        n = 0;
        while ((wlog.size() - ls) < 1 && n < 500) begin
            @(negedge avalon_clock);
            n++;
        end
        check_val("t6_in_wr_num", {29'd0, m_address}, 32'd2);
        resetn = 1'b0;
        @(negedge avalon_clock);
        check_val("t6_mwrite", {31'd0, m_write}, 32'd0);
        check_val("t6_mread", {31'd0, m_read}, 32'd0);
        check_val("t6_maddr", {29'd0, m_address}, 32'd0);
        check_val("t6_mdata", m_writedata, 32'd0);
        check_val("t6_busy", {31'd0, busy}, 32'd0);
        check_val("t6_irq", {31'd0, irq}, 32'd0);
        resetn = 1'b1;
        repeat (60) @(negedge avalon_clock);
        check_val("t6_no_more_writes", 32'(wlog.size() - ls), 32'd2);
        host_read(3'd3, rd); check_val("t6_runs_reg", rd, 32'd0);
        host_read(3'd0, rd); check_val("t6_ctrl", rd, 32'd0);

        check_val("m_exclusive", 32'(excl_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/test_run_scheduler.md
TEST_RUN_SCHEDULER -- requirements
Module: test_run_scheduler

Interface
REQ-001 Parameter POLL_GAP, default 4, idle cycles between successive status polls of the test control unit.
REQ-002 Parameter TIMEOUT, default 65535, maximum cycles allowed per run from go-write to go-clear.
REQ-003 Clock and reset: reset resetn, synchronous, active-low; clock avalon_clock.
REQ-004 avalon_clock  in  1  system clock; all logic in this single domain.
REQ-005 resetn  in  1  synchronous active-low reset.
REQ-006 s_write, s_read  in  1  host Avalon-MM slave strobes.
REQ-007 s_address  in  3  host register select.
REQ-008 s_writedata  in  32  host write data.
REQ-009 s_readdata  out  32  host read data, registered, valid the cycle after s_read.
REQ-010 m_write, m_read  out  1  master strobes to the test control unit register port, single-cycle pulses.
REQ-011 m_address  out  3  control unit register select.
REQ-012 m_writedata  out  32  control unit write data.
REQ-013 m_readdata  in  32  control unit read data, valid one cycle after m_read.
REQ-014 busy  out  1  high while a batch is in progress.
REQ-015 irq  out  1  level, set on batch end, cleared by a host write to CTRL.

Function
REQ-016 Host map: 0 CTRL (w: bit0 start, bit1 abort; r: bit0 busy, bit1 done, bit2 timeout_err, bit3 abort_seen); 1 BASE[10:0]; 2 CHUNK[11:0]; 3 RUNS[7:0]; 4 RUNS_DONE[7:0] (r); 5 LAST_CYCLES[15:0] (r). Unmapped reads return 0.
REQ-017 Control unit map driven: addr 0 go (bit0); addr 1 set_addr; addr 2 num (exclusive end address); addr 3 pll_lock (bit0).
REQ-018 FSM states: IDLE, LOCK_RD, LOCK_CHK, WR_ADDR, WR_NUM, WR_GO, POLL_RD, POLL_CHK, GAP, NEXT, FINISH.
REQ-019 IDLE -> LOCK_RD on start written 1 when RUNS != 0 and CHUNK != 0; otherwise start is ignored and done/err bits unchanged.
REQ-020 Start accepted: clear done, timeout_err, abort_seen, RUNS_DONE, irq; cur_addr <= BASE.
REQ-021 LOCK_RD issues m_read addr 3; LOCK_CHK samples m_readdata[0]: 1 -> WR_ADDR, 0 -> LOCK_RD (re-poll indefinitely; abort still honoured).
REQ-022 WR_ADDR writes cur_addr to addr 1; WR_NUM writes end = min(cur_addr+CHUNK, 2048) to addr 2 (13-bit sum, no wrap); WR_GO writes 1 to addr 0 and clears the run cycle counter.
REQ-023 POLL_RD issues m_read addr 0; POLL_CHK samples bit0: 0 -> NEXT, 1 -> GAP; GAP waits POLL_GAP cycles then -> POLL_RD.
REQ-024 Run cycle counter increments every cycle from WR_GO until go-clear, saturating at 16 bits; copied to LAST_CYCLES on go-clear.
REQ-025 Counter reaching TIMEOUT in POLL_RD/POLL_CHK/GAP: write 0 to addr 0, set timeout_err, -> FINISH.
REQ-026 NEXT: RUNS_DONE++; cur_addr <= end; if RUNS_DONE+1 == RUNS or end == 2048 -> FINISH, else -> WR_ADDR (no lock re-check).
REQ-027 FINISH: set done, set irq, drop busy, -> IDLE next cycle.
REQ-028 Abort written 1 while busy: complete any pulse in progress, write 0 to addr 0, set abort_seen, -> FINISH; abort in IDLE ignored.
REQ-029 Start written while busy is ignored; BASE/CHUNK/RUNS writes while busy take effect only at next start (latched at start).
REQ-030 At most one of m_write/m_read high per cycle; never on two consecutive cycles to the same address without the state change above.
REQ-031 Simultaneous start and abort in one write: abort wins when busy, start wins when idle.

Reset
REQ-032 On resetn low at a clock edge: state IDLE; busy, irq, m_write, m_read 0; m_address, m_writedata, s_readdata 0; all host registers and counters 0.
REQ-033 Reset mid-batch abandons the run without writing go=0; the control unit resets itself independently.

Verification
REQ-034 Lock=1, BASE=0, CHUNK=256, RUNS=2, model clears go 40 cycles after set -> writes (1,0),(2,256),(0,1),(1,256),(2,512),(0,1); RUNS_DONE=2; irq=1.
REQ-035 BASE=1900, CHUNK=256, RUNS=4 -> single run with num=2048; RUNS_DONE=1; done=1.
REQ-036 Lock held 0 for 100 cycles then 1 -> only addr 3 reads until lock, then normal run sequence.
REQ-037 TIMEOUT=200, model never clears go -> write (0,0) at count 200; timeout_err=1, irq=1, busy=0.
REQ-038 Abort during GAP of run 1 of 3 -> write (0,0), abort_seen=1, RUNS_DONE=0, FINISH.
REQ-039 resetn low during WR_NUM -> next cycle all outputs 0, state IDLE, no further m_write.
